seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised multi-symbol sequence detector. Accepts a stream of W-bit symbols over a
//  sent/ready handshake and pulses match when the last N accepted symbols equal a
//  runtime-loadable pattern. Supports overlapping and non-overlapping detection, and keeps
//  a saturating match counter. Sits between the symbol source and the control logic.
// PARAMETERS
//  W          8            symbol width in bits
//  N          4            pattern length in symbols (N >= 2)
//  CNT_W      8            match_count width
//  OVERLAP    1            1: overlapping matches allowed; 0: window cleared after each match
//  PAT_RESET  {N*W{1'b0}}  pattern register value after reset
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high reset
//  data         in   W      symbol; valid when sent=1
//  sent         in   1      source asserts when data is valid
//  ready        out  1      detector can accept a symbol; a transfer occurs when sent&&ready
//  pattern_in   in   N*W    new pattern; bits [N*W-1 -: W] are the first symbol in the sequence
//  load_pat     in   1      1-cycle strobe: capture pattern_in
//  match        out  1      1-cycle pulse: the completing symbol was accepted on the previous edge
//  match_count  out  CNT_W  number of matches since reset or load; saturates at all-ones
//  fill         out  $clog2(N+1)  number of valid symbols in the window (0..N)
// BEHAVIOUR
//  - Reset (sync, highest priority): state=FILL, window=0, fill=0, match=0, match_count=0,
//    pattern=PAT_RESET, ready=1. A reset in the middle of a sequence discards partial progress.
//  - Window: on each transfer, window <= {window[(N-1)*W-1:0], data}. The newest symbol is
//    always in bits [W-1:0], so the compare is window == pattern.
//  - ready is combinational: ready = (state != LOAD). No other backpressure.
//  - FSM:
//      FILL:  fill < N. A transfer increments fill; when fill reaches N -> ARMED.
//      ARMED: fill == N. Each transfer shifts the window and evaluates the match.
//      LOAD:  one cycle after load_pat. ready=0, window/fill cleared -> FILL.
//  - Match evaluation: match is evaluated on the shifted window, including the symbol that
//    brings fill to N. match is registered: it is high the cycle after the completing
//    transfer, for exactly one cycle.
//  - OVERLAP=1: the window is kept after a match, so the next transfer can match again.
//  - OVERLAP=0: after a match, fill<=0 and the state returns to FILL. A new match needs N
//    fresh symbols.
//  - match_count: increments by 1 on each match pulse and holds at 2**CNT_W-1 (no wrap).
//  - load_pat (any state except during reset):
//      - pattern<=pattern_in; state->LOAD; match_count<=0.
//      - A transfer in the same cycle is consumed and discarded; no match is evaluated for it.
//  - load_pat while in LOAD: the pattern is re-captured and LOAD is held one more cycle.
//  - sent while ready=0: no transfer; the source must hold data and sent.
//  - No transfer (sent=0) leaves window, fill and state unchanged; match returns to 0.
// TESTING (W=8, N=3, CNT_W=4 unless stated; pattern={8'h57,8'h57,8'h57})
//  1 Reset: assert reset mid-stream (fill=2) -> next cycle fill=0, match=0, match_count=0,
//    ready=1, pattern=PAT_RESET.
//  2 Basic: load pattern {8'h12,8'h34,8'h57}, then send 12,34,57 -> single match pulse the
//    cycle after 57 is accepted; match_count=1. Send 12,34,58 -> no match.
//  3 Overlap: OVERLAP=1, send 57,57,57,57,57 -> matches after the 3rd, 4th and 5th symbols;
//    match_count=3. Same stream with OVERLAP=0 -> match after the 3rd only; count=1.
//    A 6th 57 gives the second match.
//  4 Handshake gaps: the pattern with sent deasserted for random 0-5 cycles between symbols ->
//    the match still fires once; the window is unaffected by idle cycles.
//  5 Load collision: load_pat with sent=1, data=57 -> symbol discarded, ready=0 next cycle,
//    fill=0, count=0. A subsequent 57,57 gives no match; a third 57 gives a match.
//  6 Saturation: CNT_W=4, OVERLAP=1, 20 matches -> match_count holds at 15; the match pulse
//    still fires every time.

Source files
------------

// File: rtl/seq_detector_param.sv
// Sequence detector: shifts accepted W-bit symbols into an N-deep window and pulses
// match when the window equals a runtime-loadable pattern; counts matches with saturation.
module seq_detector_param #(
    parameter int             W         = 8,
    parameter int             N         = 4,
    parameter int             CNT_W     = 8,
    parameter bit             OVERLAP   = 1'b1,
    parameter logic [N*W-1:0] PAT_RESET = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [W-1:0]             data,
    input  logic                     sent,
    output logic                     ready,
    input  logic [N*W-1:0]           pattern_in,
    input  logic                     load_pat,
    output logic                     match,
    output logic [CNT_W-1:0]         match_count,
    output logic [$clog2(N+1)-1:0]   fill,
    output logic [1:0]               state
);

    localparam int FW = $clog2(N+1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ARMED = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Handshake: a symbol transfers on a rising edge where sent && ready.
    // ready drops only for the single LOAD cycle after a pattern load.

    state_t         fsm;
    logic [N*W-1:0] window;
    logic [N*W-1:0] pattern;
    logic [N*W-1:0] shifted;
    logic [FW-1:0]  fill_next;
    logic           hit;

    assign ready     = (fsm != LOAD);
    assign state     = fsm;
    assign shifted   = {window[(N-1)*W-1:0], data};
    assign fill_next = (fill == FW'(N)) ? fill : fill + FW'(1);
    // The symbol that brings fill up to N is already eligible to complete a match.
    assign hit       = (fill_next == FW'(N)) && (shifted == pattern);

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm         <= FILL;
            window      <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
            pattern     <= PAT_RESET;
        end else if (load_pat) begin
            // Any symbol offered this cycle is swallowed without evaluation.
            pattern     <= pattern_in;
            fsm         <= LOAD;
            match_count <= '0;
            match       <= 1'b0;
            window      <= '0;
            fill        <= '0;
        end else begin
            match <= 1'b0;
            case (fsm)
                LOAD: fsm <= FILL;
                default: begin
                    if (sent) begin
                        match <= hit;
                        if (hit && (match_count != '1))
                            match_count <= match_count + CNT_W'(1);
                        if (hit && !OVERLAP) begin
                            window <= '0;
                            fill   <= '0;
                            fsm    <= FILL;
                        end else begin
                            window <= shifted;
                            fill   <= fill_next;
                            fsm    <= (fill_next == FW'(N)) ? ARMED : FILL;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: an overlapping and a non-overlapping instance share
// stimulus and are checked every cycle against a symbol-history reference model.
module tb_seq_detector_param;

    localparam int W     = 8;
    localparam int N     = 3;
    localparam int CNT_W = 4;
    localparam int FW    = $clog2(N+1);
    localparam logic [N*W-1:0] PAT_RST = '0;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [W-1:0]     data;
    logic             sent;
    logic [N*W-1:0]   pattern_in;
    logic             load_pat;

    logic             ready_ov, ready_no;
    logic             match_ov, match_no;
    logic [CNT_W-1:0] count_ov, count_no;
    logic [FW-1:0]    fill_ov, fill_no;
    logic [1:0]       state_ov, state_no;

    int checks = 0;
    int errors = 0;

    seq_detector_param #(.W(W), .N(N), .CNT_W(CNT_W), .OVERLAP(1'b1), .PAT_RESET(PAT_RST)) dut_ov (
        .clk(clk), .reset(reset), .data(data), .sent(sent), .ready(ready_ov),
        .pattern_in(pattern_in), .load_pat(load_pat), .match(match_ov),
        .match_count(count_ov), .fill(fill_ov), .state(state_ov)
    );

    seq_detector_param #(.W(W), .N(N), .CNT_W(CNT_W), .OVERLAP(1'b0), .PAT_RESET(PAT_RST)) dut_no (
        .clk(clk), .reset(reset), .data(data), .sent(sent), .ready(ready_no),
        .pattern_in(pattern_in), .load_pat(load_pat), .match(match_no),
        .match_count(count_no), .fill(fill_no), .state(state_no)
    );

    always #5 clk = ~clk;

    // Reference model: history of accepted symbols since the last clear.
    logic [W-1:0]   hist_ov[$];
    logic [W-1:0]   hist_no[$];
    logic [N*W-1:0] pat;
    int             cnt_ov, cnt_no;
    bit             exp_match_ov, exp_match_no;
    bit             in_load;

    function automatic bit tail_matches(input logic [W-1:0] q[$], input logic [N*W-1:0] p);
        logic [W-1:0] want;
        if (q.size() < N) return 1'b0;
        for (int i = 0; i < N; i++) begin
            want = p[(N-1-i)*W +: W];
            if (q[q.size()-N+i] !== want) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int min_n(input int v);
        return (v < N) ? v : N;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ov match", 32'(match_ov), 32'(exp_match_ov));
        chk("ov count", 32'(count_ov), 32'(cnt_ov));
        chk("ov fill",  32'(fill_ov),  32'(min_n(hist_ov.size())));
        chk("ov ready", 32'(ready_ov), 32'(!in_load));
        chk("no match", 32'(match_no), 32'(exp_match_no));
        chk("no count", 32'(count_no), 32'(cnt_no));
        chk("no fill",  32'(fill_no),  32'(min_n(hist_no.size())));
        chk("no ready", 32'(ready_no), 32'(!in_load));
    endtask

    task automatic do_reset();
        reset = 1'b1; sent = 1'b0; load_pat = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        hist_ov.delete(); hist_no.delete();
        pat = PAT_RST; cnt_ov = 0; cnt_no = 0;
        exp_match_ov = 1'b0; exp_match_no = 1'b0; in_load = 1'b0;
        check_all();
    endtask

    task automatic cycle(input logic s, input logic [W-1:0] d, input logic ld, input logic [N*W-1:0] p);
        sent = s; data = d; load_pat = ld; pattern_in = p;
        exp_match_ov = 1'b0; exp_match_no = 1'b0;
        if (ld) begin
            pat = p; hist_ov.delete(); hist_no.delete();
            cnt_ov = 0; cnt_no = 0; in_load = 1'b1;
        end else if (in_load) begin
            in_load = 1'b0;
        end else if (s) begin
            hist_ov.push_back(d);
            if (hist_ov.size() > N) void'(hist_ov.pop_front());
            exp_match_ov = tail_matches(hist_ov, pat);
            if (exp_match_ov && cnt_ov < CNT_MAX) cnt_ov++;
            hist_no.push_back(d);
            if (hist_no.size() > N) void'(hist_no.pop_front());
            exp_match_no = tail_matches(hist_no, pat);
            if (exp_match_no) begin
                hist_no.delete();
                if (cnt_no < CNT_MAX) cnt_no++;
            end
        end
        @(posedge clk); #1;
        sent = 1'b0; load_pat = 1'b0;
        check_all();
    endtask

    task automatic send(input logic [W-1:0] d);
        cycle(1'b1, d, 1'b0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom), 1'b0, '0);
    endtask

    task automatic load(input logic [N*W-1:0] p);
        cycle(1'b0, '0, 1'b1, p);
        idle(1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 2))
            0:       return 8'h57;
            1:       return 8'h12;
            default: return 8'h34;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; sent = 1'b0; load_pat = 1'b0; data = '0; pattern_in = '0;
        do_reset();

        // Pattern after reset is all zeros.
        send(8'h00); send(8'h00); send(8'h00);
        chk("rst pattern match", 32'(match_ov), 32'd1);

        // Mid-stream reset with two symbols buffered.
        do_reset();
        send(8'h12); send(8'h34);
        do_reset();
        chk("mid reset fill", 32'(fill_ov), 32'd0);

        // Basic match, then a near miss.
        load({8'h12, 8'h34, 8'h57});
        send(8'h12); send(8'h34); send(8'h57);
        chk("basic count", 32'(count_ov), 32'd1);
        send(8'h12); send(8'h34); send(8'h58);
        chk("near miss", 32'(match_ov), 32'd0);

        // Overlapping versus non-overlapping runs.
        load({8'h57, 8'h57, 8'h57});
        for (int i = 0; i < 5; i++) send(8'h57);
        chk("overlap count", 32'(count_ov), 32'd3);
        chk("nonoverlap count", 32'(count_no), 32'd1);
        send(8'h57);
        chk("nonoverlap sixth", 32'(match_no), 32'd1);

        // Idle gaps between symbols.
        load({8'h12, 8'h34, 8'h57});
        idle($urandom_range(0, 5)); send(8'h12);
        idle($urandom_range(0, 5)); send(8'h34);
        idle($urandom_range(0, 5)); send(8'h57);
        chk("gap match", 32'(match_ov), 32'd1);
        idle($urandom_range(1, 5));

        // Load colliding with a transfer.
        cycle(1'b1, 8'h57, 1'b1, {8'h57, 8'h57, 8'h57});
        chk("collide ready", 32'(ready_ov), 32'd0);
        idle(1);
        send(8'h57); send(8'h57);
        chk("collide no match", 32'(match_ov), 32'd0);
        send(8'h57);
        chk("collide match", 32'(match_ov), 32'd1);

        // Counter saturation: 20 matches.
        load({8'h57, 8'h57, 8'h57});
        for (int i = 0; i < 22; i++) send(8'h57);
        chk("sat count", 32'(count_ov), 32'(CNT_MAX));
        chk("sat pulse", 32'(match_ov), 32'd1);

        // Randomized traffic with occasional reloads from a small alphabet.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0)
                cycle($urandom_range(0, 1) == 1, pick(), 1'b1, {pick(), pick(), pick()});
            else
                cycle($urandom_range(0, 3) != 0, pick(), 1'b0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
